// File: rtl/aes_periph_pkg.sv
// Shared definitions for the AES SPI register bank: address map, CTRL and
// STATUS bit positions, transaction widths, control FSM states and the
// partial-write merge helper.
package aes_periph_pkg;

    // Word addresses
    localparam int ADDR_KEY0   = 'h0;
    localparam int ADDR_DIN0   = 'h4;
    localparam int ADDR_CTRL   = 'h8;
    localparam int ADDR_STATUS = 'h9;
    localparam int ADDR_DOUT0  = 'hC;

    // CTRL register bits (start and clear are pulses, auto is sticky)
    localparam int CTRL_START = 0;
    localparam int CTRL_CLEAR = 1;
    localparam int CTRL_AUTO  = 2;

    // STATUS byte bits
    localparam int STAT_BUSY = 7;
    localparam int STAT_DONE = 6;
    localparam int STAT_ERR  = 5;
    localparam int STAT_AUTO = 4;

    typedef enum logic [1:0] {
        TW_BYTE     = 2'b00,
        TW_HALF     = 2'b01,
        TW_WORD     = 2'b10,
        TW_WORD_ALT = 2'b11
    } txn_width_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2
    } ctrl_state_e;

    // Narrow writes replace only the low byte/half; upper bits are kept.
    function automatic logic [31:0] merge_write(input logic [31:0] old_val,
                                                input logic [31:0] wr_val,
                                                input logic [1:0]  width);
        logic [31:0] result;
        case (txn_width_e'(width))
            TW_BYTE: result = {old_val[31:8],  wr_val[7:0]};
            TW_HALF: result = {old_val[31:16], wr_val[15:0]};
            default: result = wr_val;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/aes_spi_regfile_if.sv
// Register-access bus between the SPI front end (master) and the AES
// register bank (slave).
interface aes_spi_regfile_if #(
    parameter int ADDR_W = 4,
    parameter int REG_W  = 32
);
    logic [ADDR_W-1:0] reg_addr;
    logic [REG_W-1:0]  reg_data_i;
    logic              reg_data_dv;
    logic              reg_addr_v;
    logic [1:0]        txn_width;
    logic [REG_W-1:0]  reg_data_o;
    logic [7:0]        status;

    modport master (
        output reg_addr, reg_data_i, reg_data_dv, reg_addr_v, txn_width,
        input  reg_data_o, status
    );

    modport slave (
        input  reg_addr, reg_data_i, reg_data_dv, reg_addr_v, txn_width,
        output reg_data_o, status
    );
endinterface

// File: rtl/aes_ctrl_fsm.sv
// AES core sequencing: IDLE -> START (one-cycle start pulse) -> RUN until the
// core reports completion. Owns the busy/done/err flags.
module aes_ctrl_fsm
    import aes_periph_pkg::*;
(
    input  logic clk,
    input  logic rstb,
    input  logic ena,
    input  logic i_start_req,   // CTRL.start or auto-start request
    input  logic i_clear,       // CTRL.clear
    input  logic i_kd_wr,       // KEY/DIN write attempt
    input  logic i_aes_done,
    output logic o_aes_start,
    output logic o_busy,
    output logic o_done,
    output logic o_err,
    output logic o_capture      // latch ciphertext this cycle
);

    ctrl_state_e r_state;
    logic        r_aes_start;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    assign o_aes_start = r_aes_start;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_capture   = ena && (r_state == ST_RUN) && i_aes_done;

    // State sequencing and flag updates; later assignments take priority,
    // so clear acts first and completion / busy violations override it.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state     <= ST_IDLE;
            r_aes_start <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else if (ena) begin
            r_aes_start <= 1'b0;
            if (i_clear) begin
                r_done <= 1'b0;
                r_err  <= 1'b0;
            end
            if (r_busy && (i_start_req || i_kd_wr)) begin
                r_err <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_start_req) begin
                        r_state     <= ST_START;
                        r_aes_start <= 1'b1;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                    end
                end
                ST_START: begin
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (i_aes_done) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/aes_spi_regfile.sv
// AES register bank behind the SPI register-access front end. Holds the key,
// plaintext, control and ciphertext words, drives the combinational read mux
// and status byte, and hands start/done sequencing to aes_ctrl_fsm.
// Build option: define AES_KEY_READBACK_EN to make KEY words readable;
// otherwise KEY reads return 0.
module aes_spi_regfile
    import aes_periph_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int REG_W  = 32
)(
    input  logic                 clk,
    input  logic                 rstb,
    input  logic                 ena,
    aes_spi_regfile_if.slave     bus,
    output logic [4*REG_W-1:0]   aes_key,
    output logic [4*REG_W-1:0]   aes_din,
    output logic                 aes_start,
    input  logic                 aes_done,
    input  logic [4*REG_W-1:0]   aes_dout
);

    localparam logic [ADDR_W-1:0] GRP_KEY  = ADDR_W'(ADDR_KEY0  / 4);
    localparam logic [ADDR_W-1:0] GRP_DIN  = ADDR_W'(ADDR_DIN0  / 4);
    localparam logic [ADDR_W-1:0] GRP_DOUT = ADDR_W'(ADDR_DOUT0 / 4);
    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(ADDR_CTRL);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(ADDR_STATUS);

    logic [ADDR_W-1:0]       w_group;
    logic [1:0]              w_slot;
    logic                    w_wr;
    logic                    w_is_key;
    logic                    w_is_din;
    logic                    w_is_ctrl;
    logic                    w_key_wr_ok;
    logic                    w_din_wr_ok;
    logic                    w_start_req;
    logic                    w_clear;
    logic                    w_busy;
    logic                    w_done;
    logic                    w_err;
    logic                    w_capture;
    logic                    r_auto;
    logic [7:0]              w_status;
    logic [REG_W-1:0]        w_rdata;
    logic [3:0][REG_W-1:0]   w_key_words;
    logic [3:0][REG_W-1:0]   w_din_words;
    logic [3:0][REG_W-1:0]   w_dout_words;

    // The front end samples reg_data_o combinationally; the read strobe has
    // no side effects here.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, bus.reg_addr_v};

    assign w_group   = bus.reg_addr >> 2;
    assign w_slot    = bus.reg_addr[1:0];
    assign w_wr      = ena && bus.reg_data_dv;
    assign w_is_key  = (w_group == GRP_KEY);
    assign w_is_din  = (w_group == GRP_DIN);
    assign w_is_ctrl = (bus.reg_addr == A_CTRL);

    // KEY/DIN are frozen while the core is busy; the attempt flags err.
    assign w_key_wr_ok = w_wr && w_is_key && !w_busy;
    assign w_din_wr_ok = w_wr && w_is_din && !w_busy;

    // Auto-start fires on a write to the last plaintext word.
    assign w_start_req = w_wr && ((w_is_ctrl && bus.reg_data_i[CTRL_START]) ||
                                  (w_is_din && (w_slot == 2'd3) && r_auto));
    assign w_clear     = w_wr && w_is_ctrl && bus.reg_data_i[CTRL_CLEAR];

    aes_ctrl_fsm u_ctrl_fsm (
        .clk         (clk),
        .rstb        (rstb),
        .ena         (ena),
        .i_start_req (w_start_req),
        .i_clear     (w_clear),
        .i_kd_wr     (w_wr && (w_is_key || w_is_din)),
        .i_aes_done  (aes_done),
        .o_aes_start (aes_start),
        .o_busy      (w_busy),
        .o_done      (w_done),
        .o_err       (w_err),
        .o_capture   (w_capture)
    );

    // Sticky auto-start enable, rewritten by every CTRL write.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_auto <= 1'b0;
        end else if (w_wr && w_is_ctrl) begin
            r_auto <= bus.reg_data_i[CTRL_AUTO];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_word
            logic [REG_W-1:0] r_key_w;
            logic [REG_W-1:0] r_din_w;
            logic [REG_W-1:0] r_dout_w;

            // Per-word storage: host writes to KEY/DIN, ciphertext capture to DOUT.
            always_ff @(posedge clk or negedge rstb) begin
                if (!rstb) begin
                    r_key_w  <= '0;
                    r_din_w  <= '0;
                    r_dout_w <= '0;
                end else if (ena) begin
                    if (w_key_wr_ok && (w_slot == 2'(gi))) begin
                        r_key_w <= merge_write(r_key_w, bus.reg_data_i, bus.txn_width);
                    end
                    if (w_din_wr_ok && (w_slot == 2'(gi))) begin
                        r_din_w <= merge_write(r_din_w, bus.reg_data_i, bus.txn_width);
                    end
                    if (w_capture) begin
                        r_dout_w <= aes_dout[gi*REG_W +: REG_W];
                    end
                end
            end

            assign w_key_words[gi]  = r_key_w;
            assign w_din_words[gi]  = r_din_w;
            assign w_dout_words[gi] = r_dout_w;
        end
    endgenerate

    assign aes_key = w_key_words;
    assign aes_din = w_din_words;

    // Status byte assembled from the FSM flags and the auto bit.
    always_comb begin
        w_status            = '0;
        w_status[STAT_BUSY] = w_busy;
        w_status[STAT_DONE] = w_done;
        w_status[STAT_ERR]  = w_err;
        w_status[STAT_AUTO] = r_auto;
    end

    // Combinational read mux; unmapped slots read as zero.
    always_comb begin
        w_rdata = '0;
        if (w_is_key) begin
`ifdef AES_KEY_READBACK_EN
            w_rdata = w_key_words[w_slot];
`else
            w_rdata = '0;
`endif
        end else if (w_is_din) begin
            w_rdata = w_din_words[w_slot];
        end else if (w_group == GRP_DOUT) begin
            w_rdata = w_dout_words[w_slot];
        end else if (w_is_ctrl) begin
            w_rdata[CTRL_AUTO] = r_auto;
        end else if (bus.reg_addr == A_STATUS) begin
            w_rdata[7:0] = w_status;
        end
    end

    assign bus.reg_data_o = w_rdata;
    assign bus.status     = w_status;

endmodule

// File: tb/tb_aes_spi_regfile.sv
// Self-checking bench for aes_spi_regfile: directed steps from the register
// map description followed by random traffic, all checked against a
// transaction-level model of the register bank.
module tb_aes_spi_regfile;
    import aes_periph_pkg::*;

    logic         clk = 1'b0;
    logic         rstb = 1'b0;
    logic         ena = 1'b1;
    logic         aes_done = 1'b0;
    logic [127:0] aes_dout = '0;
    logic [127:0] aes_key;
    logic [127:0] aes_din;
    logic         aes_start;

    aes_spi_regfile_if #(.ADDR_W(4), .REG_W(32)) bus_if ();

    aes_spi_regfile #(.ADDR_W(4), .REG_W(32)) dut (
        .clk       (clk),
        .rstb      (rstb),
        .ena       (ena),
        .bus       (bus_if.slave),
        .aes_key   (aes_key),
        .aes_din   (aes_din),
        .aes_start (aes_start),
        .aes_done  (aes_done),
        .aes_dout  (aes_dout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // ---------------- reference model ----------------
    logic [31:0] m_key [4];
    logic [31:0] m_din [4];
    logic [31:0] m_dout[4];
    bit m_auto, m_busy, m_done, m_err, m_start_now;

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_key[i] = '0; m_din[i] = '0; m_dout[i] = '0;
        end
        m_auto = 0; m_busy = 0; m_done = 0; m_err = 0; m_start_now = 0;
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [1:0] w);
        logic [31:0] keep;
        keep = (w == 2'd0) ? 32'hFFFF_FF00 : (w == 2'd1) ? 32'hFFFF_0000 : 32'h0;
        return (old_v & keep) | (new_v & ~keep);
    endfunction

    function automatic logic [7:0] m_status();
        return (m_busy ? 8'h80 : 8'h00) | (m_done ? 8'h40 : 8'h00) |
               (m_err ? 8'h20 : 8'h00) | (m_auto ? 8'h10 : 8'h00);
    endfunction

    function automatic logic [31:0] m_read(input int a);
        if (a < 4) begin
`ifdef AES_KEY_READBACK_EN
            return m_key[a];
`else
            return 32'h0;
`endif
        end
        if (a < 8)   return m_din[a-4];
        if (a == 8)  return m_auto ? 32'h4 : 32'h0;
        if (a == 9)  return {24'h0, m_status()};
        if (a >= 12) return m_dout[a-12];
        return 32'h0;
    endfunction

    // One clock of the register bank's behaviour, applied at the active edge.
    function automatic void model_clock(input int a, input logic [31:0] d, input bit dv,
                                        input logic [1:0] w, input bit dn, input logic [127:0] dout);
        bit req = 0;
        bit in_run = m_busy && !m_start_now;
        bit go = 0;
        if (dv) begin
            if (a < 4) begin
                if (m_busy) m_err = 1; else m_key[a] = ref_merge(m_key[a], d, w);
            end else if (a < 8) begin
                if (m_busy) m_err = 1; else m_din[a-4] = ref_merge(m_din[a-4], d, w);
                if (a == 7 && m_auto) req = 1;
            end else if (a == 8) begin
                if (d[1]) begin m_done = 0; m_err = 0; end
                m_auto = d[2];
                if (d[0]) req = 1;
            end
        end
        if (req) begin
            if (m_busy) m_err = 1;
            else begin go = 1; m_done = 0; end
        end
        if (in_run && dn) begin
            for (int i = 0; i < 4; i++) m_dout[i] = dout[i*32 +: 32];
            m_done = 1;
            m_busy = 0;
        end
        if (go) m_busy = 1;
        m_start_now = go;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic peek(input logic [3:0] a, input logic [31:0] exp, input string tag);
        bus_if.reg_addr   = a;
        bus_if.reg_addr_v = 1'b1;
        #1;
        chk(tag, {96'h0, bus_if.reg_data_o}, {96'h0, exp});
        bus_if.reg_addr_v = 1'b0;
    endtask

    // One bus transaction: drive after negedge, check pre-edge state, advance model.
    task automatic step(input logic [3:0] a, input logic [31:0] d, input bit dv, input logic [1:0] w,
                        input bit en, input bit dn, input logic [127:0] dout, input string tag);
        @(negedge clk);
        bus_if.reg_addr    = a;
        bus_if.reg_data_i  = d;
        bus_if.reg_data_dv = dv;
        bus_if.reg_addr_v  = !dv;
        bus_if.txn_width   = w;
        ena                = en;
        aes_done           = dn;
        aes_dout           = dout;
        #1;
        chk({tag, ":rd"},     {96'h0, bus_if.reg_data_o}, {96'h0, m_read(int'(a))});
        chk({tag, ":status"}, {120'h0, bus_if.status},    {120'h0, m_status()});
        chk({tag, ":start"},  {127'h0, aes_start},        {127'h0, m_start_now});
        chk({tag, ":key"},    aes_key, {m_key[3], m_key[2], m_key[1], m_key[0]});
        chk({tag, ":din"},    aes_din, {m_din[3], m_din[2], m_din[1], m_din[0]});
        $display("[%0t] %s a=%h d=%h dv=%0d w=%0d en=%0d dn=%0d rd=%h st=%h",
                 $time, tag, a, d, dv, w, en, dn, bus_if.reg_data_o, bus_if.status);
        @(posedge clk);
        if (en) model_clock(int'(a), d, dv, w, dn, dout);
        #1;
        bus_if.reg_data_dv = 1'b0;
        aes_done           = 1'b0;
        ena                = 1'b1;
    endtask

    task automatic idle(input string tag);
        step(4'h9, 32'h0, 1'b0, 2'b10, 1'b1, 1'b0, 128'h0, tag);
    endtask

    localparam logic [127:0] KEY_VAL  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] DIN_VAL  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] DOUT_VAL = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    initial begin
        logic [127:0] kv;
        logic [127:0] dvv;
        logic [31:0]  key0_exp;
        kv  = KEY_VAL;
        dvv = DIN_VAL;

        bus_if.reg_addr    = '0;
        bus_if.reg_data_i  = '0;
        bus_if.reg_data_dv = 1'b0;
        bus_if.reg_addr_v  = 1'b0;
        bus_if.txn_width   = 2'b10;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_status", {120'h0, bus_if.status}, 128'h0);
        chk("rst_start",  {127'h0, aes_start},     128'h0);
        peek(4'h0, 32'h0, "rst_addr0");
        peek(4'hC, 32'h0, "rst_dout0");
        peek(4'h8, 32'h0, "rst_ctrl");
        @(negedge clk);
        rstb = 1'b1;

        // Key / plaintext load and a full encryption handshake
        for (int i = 0; i < 4; i++) step(4'(i),     kv[i*32 +: 32],  1, 2'b10, 1, 0, 128'h0, "key_wr");
        for (int i = 0; i < 4; i++) step(4'(4 + i), dvv[i*32 +: 32], 1, 2'b10, 1, 0, 128'h0, "din_wr");
        step(4'h8, 32'h1, 1, 2'b10, 1, 0, 128'h0, "ctrl_start");
        chk("start_pulse", {127'h0, aes_start}, 128'h1);
        peek(4'h9, 32'h80, "busy_status");
        idle("start_cycle");
        chk("start_once", {127'h0, aes_start}, 128'h0);
        idle("run_cycle");
        step(4'h9, 32'h0, 0, 2'b10, 1, 1, DOUT_VAL, "aes_done");
        peek(4'hC, 32'h70b4c55a, "dout0");
        peek(4'hF, 32'h69c4e0d8, "dout3");
        peek(4'h9, 32'h40, "done_status");

        // Narrow writes merge into the low bits
        step(4'h4, 32'h11223344, 1, 2'b10, 1, 0, 128'h0, "din0_word");
        step(4'h4, 32'hFFFFFFAB, 1, 2'b00, 1, 0, 128'h0, "din0_byte");
        peek(4'h4, 32'h112233AB, "byte_merge");
        step(4'h4, 32'hFFFFBEEF, 1, 2'b01, 1, 0, 128'h0, "din0_half");
        peek(4'h4, 32'h1122BEEF, "half_merge");

        // Auto-start, busy write error, clear
        step(4'h8, 32'h4, 1, 2'b10, 1, 0, 128'h0, "ctrl_auto");
        step(4'h7, 32'h33333333, 1, 2'b10, 1, 0, 128'h0, "din3_auto");
        peek(4'h9, 32'h90, "autostart_status");
        step(4'h4, 32'h55555555, 1, 2'b10, 1, 0, 128'h0, "din0_busy");
        peek(4'h4, 32'h1122BEEF, "busy_write_ignored");
        peek(4'h9, 32'hB0, "busy_err_status");
        step(4'h9, 32'h0, 0, 2'b10, 1, 1, ~DOUT_VAL, "aes_done2");
        peek(4'h9, 32'h70, "done_err_status");
        step(4'h8, 32'h2, 1, 2'b10, 1, 0, 128'h0, "ctrl_clear");
        peek(4'h9, 32'h00, "cleared_status");

        // Key readback depends on build option
`ifdef AES_KEY_READBACK_EN
        key0_exp = 32'h0c0d0e0f;
`else
        key0_exp = 32'h0;
`endif
        peek(4'h0, key0_exp, "key0_read");

        // Clock enable low freezes everything
        step(4'h5, 32'hDEADBEEF, 1, 2'b10, 0, 0, 128'h0, "ena0_write");
        peek(4'h5, 32'h8899aabb, "ena0_no_change");
        step(4'h8, 32'h1, 1, 2'b10, 0, 0, 128'h0, "ena0_start");
        idle("ena0_after");
        peek(4'h9, 32'h00, "ena0_no_start");

        // Clear and completion in the same cycle: done wins
        step(4'h8, 32'h1, 1, 2'b10, 1, 0, 128'h0, "start3");
        idle("start3_cycle");
        step(4'h8, 32'h2, 1, 2'b10, 1, 1, DOUT_VAL, "clear_with_done");
        peek(4'h9, 32'h40, "completion_wins");

        // Start with clear, then async reset mid-run
        step(4'h8, 32'h3, 1, 2'b10, 1, 0, 128'h0, "clear_start");
        peek(4'h9, 32'h80, "clear_start_status");
        idle("run_before_rst");
        #2;
        rstb = 1'b0;
        #1;
        model_reset();
        chk("midrun_rst_status", {120'h0, bus_if.status}, 128'h0);
        chk("midrun_rst_start",  {127'h0, aes_start},     128'h0);
        peek(4'hC, 32'h0, "midrun_rst_dout0");
        @(negedge clk);
        rstb = 1'b1;

        // Completion pulse while idle is ignored
        step(4'h9, 32'h0, 0, 2'b10, 1, 1, DOUT_VAL, "stray_done");
        peek(4'hC, 32'h0, "stray_done_dout");

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [3:0]   ra;
            logic [31:0]  rd;
            logic [127:0] rdo;
            bit           rdv, ren, rdn;
            ra  = 4'($urandom_range(0, 15));
            rd  = $urandom;
            rdv = ($urandom_range(0, 9) < 4);
            ren = ($urandom_range(0, 9) != 0);
            rdn = m_busy ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 19) == 0);
            rdo = {$urandom, $urandom, $urandom, $urandom};
            step(ra, rd, rdv, 2'($urandom_range(0, 3)), ren, rdn, rdo, "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
